// File: rtl/ram_port_arbiter_if.sv
// Bundle between the fetch/load-store requesters, the shared RAM port and the arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic [5:0]        d_op;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_done;
  logic [31:0]       d_rdata;

  logic              ram_enable;
  logic [5:0]        ram_opcode;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_mfc;

  logic              err;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_op, d_addr, d_wdata, ram_rdata, ram_mfc,
    output if_done, if_rdata, d_done, d_rdata, ram_enable, ram_opcode, ram_addr, ram_wdata,
           err, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_op, d_addr, d_wdata, ram_rdata, ram_mfc,
    input  if_done, if_rdata, d_done, d_rdata, ram_enable, ram_opcode, ram_addr, ram_wdata,
           err, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the single RAM port: alternating grant on contention, MFC
// handshake, bounded access time with an error pulse on timeout.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [5:0]  FETCH_OP    = 6'b000000
) (
  input logic               Clk,
  input logic               RESET,
  ram_port_arbiter_if.slave bus
);
  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StRelease} state_e;

  state_e            state;
  logic              last_d;
  logic              owner_d;
  logic [CntW-1:0]   cnt;
  logic              grant_d;
  logic [ADDR_W-1:0] grant_addr;

  // On a tie the requester that did not own the previous access wins.
  assign grant_d    = bus.d_req & (~bus.if_req | ~last_d);
  assign grant_addr = grant_d ? bus.d_addr : bus.if_addr;

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state          <= StIdle;
      last_d         <= 1'b0;
      owner_d        <= 1'b0;
      cnt            <= '0;
      bus.ram_enable <= 1'b0;
      bus.ram_opcode <= '0;
      bus.ram_addr   <= '0;
      bus.ram_wdata  <= '0;
      bus.if_done    <= 1'b0;
      bus.d_done     <= 1'b0;
      bus.err        <= 1'b0;
      bus.busy       <= 1'b0;
      bus.if_rdata   <= '0;
      bus.d_rdata    <= '0;
    end else begin
      bus.if_done <= 1'b0;
      bus.d_done  <= 1'b0;
      bus.err     <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.if_req || bus.d_req) begin
            owner_d        <= grant_d;
            bus.ram_opcode <= grant_d ? bus.d_op : FETCH_OP;
            bus.ram_addr   <= grant_addr;
            bus.ram_wdata  <= grant_d ? bus.d_wdata : 32'h0;
            bus.ram_enable <= 1'b1;
            bus.busy       <= 1'b1;
            cnt            <= '0;
            state          <= StAccess;
          end
        end
        StAccess: begin
          if (bus.ram_mfc) begin
            if (owner_d) begin
              bus.d_rdata <= bus.ram_rdata;
              bus.d_done  <= 1'b1;
            end else begin
              bus.if_rdata <= bus.ram_rdata;
              bus.if_done  <= 1'b1;
            end
            bus.ram_enable <= 1'b0;
            state          <= StRelease;
          end else if (cnt == CntLast) begin
            bus.d_done     <= owner_d;
            bus.if_done    <= ~owner_d;
            bus.err        <= 1'b1;
            bus.ram_enable <= 1'b0;
            state          <= StRelease;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StRelease: begin
          // Wait for the RAM to drop MFC so a stale MFC never completes the next access.
          if (!bus.ram_mfc) begin
            last_d   <= owner_d;
            bus.busy <= 1'b0;
            state    <= StIdle;
          end
        end
        default: begin
          bus.ram_enable <= 1'b0;
          bus.busy       <= 1'b0;
          state          <= StIdle;
        end
      endcase
    end
  end
endmodule
